// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if -- register bus between a bus master and the interrupt controller.
//
// Signals:
//   bus_write       write strobe (data taken on the rising clock edge)
//   bus_read        read strobe (informational; read data is combinational)
//   bus_address_in  24-bit register address
//   bus_data_in     8-bit write data
//   bus_data_out    8-bit combinational read data
//
// Modports:
//   master  drives strobes/address/write data, receives read data
//   slave   receives strobes/address/write data, drives read data
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;

  modport master (
    output bus_write,
    output bus_read,
    output bus_address_in,
    output bus_data_in,
    input  bus_data_out
  );

  modport slave (
    input  bus_write,
    input  bus_read,
    input  bus_address_in,
    input  bus_data_in,
    output bus_data_out
  );
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- 8-source prioritised interrupt controller.
//
// Sources raise level pulses on irq_in; a rising edge sets a pending flag.
// Enabled pending sources whose priority exceeds the CPU mask level compete;
// the highest priority (lowest index on ties) is presented to the CPU with
// its vector and level until acknowledged or withdrawn.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   bus          irq_ctrl_if.slave register bus
//                  24'h2020 prio src3..0, 24'h2021 prio src7..4 (2 bits each)
//                  24'h2023 enable mask, 24'h2027 pending (write 1 to clear)
//   irq_in[7:0]  interrupt sources
//   cpu_ilevel   current CPU interrupt mask level
//   irq_ack      CPU accepts the presented interrupt
//   irq_req      interrupt request to the CPU
//   irq_vector   VECTOR_BASE + winning source index (0 when idle)
//   irq_level    priority of the presented source (0 when idle)
//
// Build option:
//   IRQ_CTRL_SYNC_EN  when defined, irq_in passes through a 2-flop
//                     synchroniser before edge detection.
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter logic [7:0] VECTOR_BASE = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  irq_ctrl_if.slave  bus,
  input  logic [7:0] irq_in,
  input  logic [1:0] cpu_ilevel,
  input  logic       irq_ack,
  output logic       irq_req,
  output logic [7:0] irq_vector,
  output logic [1:0] irq_level
);

  localparam logic [23:0] ADDR_PRIO_LO = 24'h002020;
  localparam logic [23:0] ADDR_PRIO_HI = 24'h002021;
  localparam logic [23:0] ADDR_ENABLE  = 24'h002023;
  localparam logic [23:0] ADDR_PEND    = 24'h002027;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  prio_lo_q, prio_lo_d;
  logic [7:0]  prio_hi_q, prio_hi_d;
  logic [7:0]  en_q, en_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  prev_q;
  logic [1:0]  arm_q;
  logic [2:0]  win_q, win_d;
  logic [1:0]  lvl_q, lvl_d;

  logic [7:0]  irq_cond;
  logic [7:0]  edge_det;
  logic [7:0]  elig_now, elig_nx;
  logic [2:0]  best_idx;
  logic [1:0]  best_prio;
  logic        ack_clr;
  logic [7:0]  clr_mask;

  // Read strobe carries no information for this block.
  logic unused_rd;
  assign unused_rd = bus.bus_read;

  function automatic logic [1:0] prio_of(input logic [15:0] p, input int n);
    return p[2*n +: 2];
  endfunction

  function automatic logic [7:0] eligible(input logic [7:0]  pend,
                                          input logic [7:0]  en,
                                          input logic [15:0] p,
                                          input logic [1:0]  ilevel);
    logic [7:0] e;
    e = '0;
    for (int n = 0; n < 8; n++)
      e[n] = pend[n] & en[n] & (prio_of(p, n) != 2'd0) & (prio_of(p, n) > ilevel);
    return e;
  endfunction

  // Input conditioning. The arm counter masks edges until the conditioning
  // pipeline and edge history have seen real input after reset, so a source
  // already high at reset release never looks like a fresh edge.
`ifdef IRQ_CTRL_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_cond = sync2_q;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign irq_cond = irq_in;
`endif

  assign edge_det = (arm_q == ARM_CYC) ? (irq_cond & ~prev_q) : 8'h00;

  // Register writes and pending update; a new edge beats any clear.
  assign ack_clr  = (state_q == REQ) && irq_ack;

  always_comb begin
    prio_lo_d = prio_lo_q;
    prio_hi_d = prio_hi_q;
    en_d      = en_q;
    clr_mask  = '0;
    if (bus.bus_write) begin
      unique case (bus.bus_address_in)
        ADDR_PRIO_LO: prio_lo_d = bus.bus_data_in;
        ADDR_PRIO_HI: prio_hi_d = bus.bus_data_in;
        ADDR_ENABLE:  en_d      = bus.bus_data_in;
        ADDR_PEND:    clr_mask  = bus.bus_data_in;
        default:      ;
      endcase
    end
    if (ack_clr)
      clr_mask[win_q] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | edge_det;
  end

  always_comb begin
    unique case (bus.bus_address_in)
      ADDR_PRIO_LO: bus.bus_data_out = prio_lo_q;
      ADDR_PRIO_HI: bus.bus_data_out = prio_hi_q;
      ADDR_ENABLE:  bus.bus_data_out = en_q;
      ADDR_PEND:    bus.bus_data_out = pend_q;
      default:      bus.bus_data_out = 8'h00;
    endcase
  end

  // Arbitration over the current state; strict '>' keeps the lowest index on ties.
  // Withdrawal is judged on next-cycle state so a clear drops the request at once.
  assign elig_now = eligible(pend_q, en_q, {prio_hi_q, prio_lo_q}, cpu_ilevel);
  assign elig_nx  = eligible(pend_d, en_d, {prio_hi_d, prio_lo_d}, cpu_ilevel);

  always_comb begin
    best_idx  = '0;
    best_prio = '0;
    for (int n = 0; n < 8; n++) begin
      if (elig_now[n] && (prio_of({prio_hi_q, prio_lo_q}, n) > best_prio)) begin
        best_idx  = 3'(n);
        best_prio = prio_of({prio_hi_q, prio_lo_q}, n);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      IDLE: begin
        if (elig_now != 8'h00) begin
          win_d   = best_idx;
          lvl_d   = best_prio;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack)
          state_d = DONE;
        else if (!elig_nx[win_q])
          state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prio_lo_q <= '0;
      prio_hi_q <= '0;
      en_q      <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      arm_q     <= '0;
      win_q     <= '0;
      lvl_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_lo_q <= prio_lo_d;
      prio_hi_q <= prio_hi_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      prev_q    <= irq_cond;
      if (arm_q != ARM_CYC)
        arm_q <= arm_q + 2'd1;
      win_q     <= win_d;
      lvl_q     <= lvl_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_vector = irq_req ? (VECTOR_BASE + {5'b00000, win_q}) : 8'h00;
  assign irq_level  = irq_req ? lvl_q : 2'b00;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- directed bench for irq_ctrl: a register-access vector table
// followed by hand-written multi-cycle service sequences.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic [1:0] cpu_ilevel;
  logic       irq_ack;
  logic       irq_req;
  logic [7:0] irq_vector;
  logic [1:0] irq_level;

  irq_ctrl_if bus ();

  irq_ctrl #(.VECTOR_BASE(8'h08)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .irq_in     (irq_in),
    .cpu_ilevel (cpu_ilevel),
    .irq_ack    (irq_ack),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_level  (irq_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } reg_vec_t;

  reg_vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    bus.bus_write      = 1'b1;
    bus.bus_address_in = a;
    bus.bus_data_in    = d;
    tick();
    bus.bus_write      = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
    bus.bus_read       = 1'b1;
    bus.bus_address_in = a;
    #1;
    d = bus.bus_data_out;
    bus.bus_read       = 1'b0;
  endtask

  // One-cycle pulse, then wait for the conditioning pipeline so the pending
  // bit is visible on return.
  task automatic pulse(input logic [7:0] bits);
    irq_in = bits;
    tick();
    irq_in = 8'h00;
    repeat (EXTRA) tick();
  endtask

  task automatic chk_out(input string name, input logic req,
                         input logic [7:0] vec, input logic [1:0] lvl);
    chk({name, ".req"}, 32'(irq_req), 32'(req));
    chk({name, ".vec"}, 32'(irq_vector), 32'(vec));
    chk({name, ".lvl"}, 32'(irq_level), 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] rd;

  initial begin
    tbl[0]  = '{1'b0, 24'h002020, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 24'h002021, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 24'h002023, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 24'h002027, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 24'h002020, 8'hA5, 8'hA5};
    tbl[5]  = '{1'b1, 24'h002021, 8'h3C, 8'h3C};
    tbl[6]  = '{1'b1, 24'h002023, 8'hF0, 8'hF0};
    tbl[7]  = '{1'b1, 24'h002025, 8'hFF, 8'h00};
    tbl[8]  = '{1'b0, 24'h012020, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 24'h002027, 8'hFF, 8'h00};
    tbl[10] = '{1'b0, 24'h002020, 8'h00, 8'hA5};
    tbl[11] = '{1'b0, 24'h002022, 8'h00, 8'h00};

    reset              = 1'b0;
    irq_in             = 8'h00;
    cpu_ilevel         = 2'd0;
    irq_ack            = 1'b0;
    bus.bus_write      = 1'b0;
    bus.bus_read       = 1'b0;
    bus.bus_address_in = '0;
    bus.bus_data_in    = '0;
    repeat (2) tick();
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    reset = 1'b1;
    repeat (5) tick();

    // Register access table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
      bus_rd(tbl[i].addr, rd);
      chk($sformatf("tbl%0d.rd", i), 32'(rd), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d.req", i), 32'(irq_req), 32'd0);
    end
    bus_wr(24'h002020, 8'h00);
    bus_wr(24'h002021, 8'h00);
    bus_wr(24'h002023, 8'h00);

    // Basic service of source 0
    bus_wr(24'h002020, 8'h03);
    bus_wr(24'h002023, 8'h01);
    irq_ack = 1'b1;              // ack while idle must be ignored
    pulse(8'h01);
    irq_ack = 1'b0;
    bus_rd(24'h002027, rd);
    chk("basic.pend", 32'(rd), 32'h01);
    chk_out("basic.idle", 1'b0, 8'h00, 2'd0);
    tick();
    chk_out("basic.req", 1'b1, 8'h08, 2'd3);
    tick();
    chk_out("basic.hold", 1'b1, 8'h08, 2'd3);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    bus_rd(24'h002027, rd);
    chk("basic.pend_clr", 32'(rd), 32'h00);
    chk_out("basic.done", 1'b0, 8'h00, 2'd0);
    tick();
    chk_out("basic.idle2", 1'b0, 8'h00, 2'd0);
    tick();
    chk_out("basic.idle3", 1'b0, 8'h00, 2'd0);

    // Priority arbitration: src1 prio 2, src5 prio 3
    bus_wr(24'h002020, 8'h08);
    bus_wr(24'h002021, 8'h0C);
    bus_wr(24'h002023, 8'h22);
    pulse(8'h22);
    tick();
    chk_out("prio.first", 1'b1, 8'h0D, 2'd3);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("prio.done", 1'b0, 8'h00, 2'd0);
    tick();
    chk_out("prio.idle", 1'b0, 8'h00, 2'd0);
    tick();
    chk_out("prio.second", 1'b1, 8'h09, 2'd2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    repeat (2) tick();
    chk_out("prio.empty", 1'b0, 8'h00, 2'd0);

    // Tie break and mask level: src2 and src6 both prio 2
    bus_wr(24'h002020, 8'h20);
    bus_wr(24'h002021, 8'h20);
    bus_wr(24'h002023, 8'h44);
    pulse(8'h44);
    tick();
    chk_out("tie.first", 1'b1, 8'h0A, 2'd2);
    cpu_ilevel = 2'd2;
    tick();
    chk_out("mask.drop", 1'b0, 8'h00, 2'd0);
    repeat (2) tick();
    chk_out("mask.hold", 1'b0, 8'h00, 2'd0);
    bus_rd(24'h002027, rd);
    chk("mask.pend", 32'(rd), 32'h44);
    cpu_ilevel = 2'd0;
    tick();
    chk_out("mask.resume", 1'b1, 8'h0A, 2'd2);

    // Withdrawal by W1C during REQ
    bus_wr(24'h002027, 8'hFF);
    chk_out("wd.drop", 1'b0, 8'h00, 2'd0);
    bus_rd(24'h002027, rd);
    chk("wd.pend", 32'(rd), 32'h00);
    tick();
    chk_out("wd.idle", 1'b0, 8'h00, 2'd0);

    // Set wins over ack-clear on source 3
    bus_wr(24'h002020, 8'h40);
    bus_wr(24'h002021, 8'h00);
    bus_wr(24'h002023, 8'h08);
    pulse(8'h08);
    tick();
    chk_out("sw.req", 1'b1, 8'h0B, 2'd1);
    irq_in = 8'h08;
    repeat (EXTRA) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_in  = 8'h00;
    chk_out("sw.done", 1'b0, 8'h00, 2'd0);
    bus_rd(24'h002027, rd);
    chk("sw.pend", 32'(rd), 32'h08);
    tick();
    chk_out("sw.idle", 1'b0, 8'h00, 2'd0);
    tick();
    chk_out("sw.rereq", 1'b1, 8'h0B, 2'd1);

    // Asynchronous reset during REQ
    #2;
    reset = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 8'h00, 2'd0);
    bus_rd(24'h002020, rd);
    chk("rst.prio", 32'(rd), 32'h00);
    bus_rd(24'h002023, rd);
    chk("rst.en", 32'(rd), 32'h00);
    bus_rd(24'h002027, rd);
    chk("rst.pend", 32'(rd), 32'h00);
    irq_in = 8'hFF;
    repeat (3) tick();
    reset = 1'b1;
    repeat (8) tick();
    bus_rd(24'h002027, rd);
    chk("rst.held_high", 32'(rd), 32'h00);
    chk_out("rst.idle", 1'b0, 8'h00, 2'd0);
    irq_in = 8'h00;
    repeat (2) tick();
    pulse(8'h01);
    bus_rd(24'h002027, rd);
    chk("rst.new_edge", 32'(rd), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
